// File: rtl/exe_div_unit_if.sv
// rtl/exe_div_unit_if.sv - request/response bundle between the execute stage and the divide unit
//
// Purpose: groups the divide-unit handshake and datapath signals.
// Signals:
//   div_i_start   - execute stage holds a divide/remainder instruction
//   div_i_op      - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   div_i_W_instr - 32-bit word variant
//   div_i_valA    - dividend (rs1)
//   div_i_valB    - divisor (rs2)
//   div_i_flush   - kill the in-flight operation
//   div_o_busy    - stall request to the pipeline
//   div_o_valid   - one-cycle pulse, div_o_valE holds the result
//   div_o_valE    - quotient or remainder
// Modports: master = pipeline side, slave = divide unit side.

interface exe_div_unit_if #(
  parameter int XLEN = 64
);
  logic            div_i_start;
  logic [1:0]      div_i_op;
  logic            div_i_W_instr;
  logic [XLEN-1:0] div_i_valA;
  logic [XLEN-1:0] div_i_valB;
  logic            div_i_flush;
  logic            div_o_busy;
  logic            div_o_valid;
  logic [XLEN-1:0] div_o_valE;

  modport master (
    output div_i_start, div_i_op, div_i_W_instr, div_i_valA, div_i_valB, div_i_flush,
    input  div_o_busy, div_o_valid, div_o_valE
  );

  modport slave (
    input  div_i_start, div_i_op, div_i_W_instr, div_i_valA, div_i_valB, div_i_flush,
    output div_o_busy, div_o_valid, div_o_valE
  );
endinterface

// File: rtl/exe_div_unit.sv
// rtl/exe_div_unit.sv - multi-cycle restoring integer divide/remainder unit
//
// Purpose: computes DIV/DIVU/REM/REMU and their 32-bit word variants, one
// quotient bit per cycle (64 cycles normal, 32 cycles word). Divide by zero
// and signed overflow bypass the iteration and complete in one cycle.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   div   - exe_div_unit_if.slave request/response bundle

module exe_div_unit #(
  parameter int XLEN = 64
) (
  input logic           clk,
  input logic           rst_n,
  exe_div_unit_if.slave div
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

  state_t          state;
  logic [6:0]      cnt;
  logic            w_q;
  logic            rem_op_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic            valid_q;
  logic [XLEN-1:0] vale_q;

  // Word results are always sign-extended from bit 31.
  function automatic logic [XLEN-1:0] fix_w(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand decode at issue time
  logic            signed_op;
  logic [XLEN-1:0] a_eff, b_eff, mag_a, mag_b, sp_res;
  logic            neg_a, neg_b, div_zero, overflow;

  always_comb begin
    signed_op = ~div.div_i_op[0];
    if (div.div_i_W_instr) begin
      a_eff = signed_op ? {{(XLEN-32){div.div_i_valA[31]}}, div.div_i_valA[31:0]}
                        : {{(XLEN-32){1'b0}}, div.div_i_valA[31:0]};
      b_eff = signed_op ? {{(XLEN-32){div.div_i_valB[31]}}, div.div_i_valB[31:0]}
                        : {{(XLEN-32){1'b0}}, div.div_i_valB[31:0]};
    end else begin
      a_eff = div.div_i_valA;
      b_eff = div.div_i_valB;
    end
    neg_a    = signed_op & a_eff[XLEN-1];
    neg_b    = signed_op & b_eff[XLEN-1];
    mag_a    = neg_a ? -a_eff : a_eff;
    mag_b    = neg_b ? -b_eff : b_eff;
    div_zero = (b_eff == '0);
    overflow = signed_op & (b_eff == '1) &
               (a_eff == (div.div_i_W_instr ? MIN_W : MIN_D));
    // Divide by zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
    if (div.div_i_op[1])
      sp_res = div_zero ? a_eff : '0;
    else
      sp_res = div_zero ? '1 : a_eff;
  end

  // One restoring step. The dividend is shifted out of quo_q MSB-first while
  // quotient bits shift in at the bottom; the top bit of diff is the borrow.
  logic [XLEN:0]   rem_shift, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nxt, quo_nxt, q_fin, r_fin, res_fin;
  logic            last;

  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    ge        = ~diff[XLEN];
    rem_nxt   = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_nxt   = {quo_q[XLEN-2:0], ge};
    q_fin     = neg_q_q ? -quo_nxt : quo_nxt;
    r_fin     = neg_r_q ? -rem_nxt : rem_nxt;
    res_fin   = fix_w(w_q, rem_op_q ? r_fin : q_fin);
    last      = (cnt == (w_q ? 7'd31 : 7'd63));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      w_q      <= 1'b0;
      rem_op_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      valid_q  <= 1'b0;
      vale_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (div.div_i_flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (div.div_i_start) begin
              w_q      <= div.div_i_W_instr;
              rem_op_q <= div.div_i_op[1];
              neg_q_q  <= neg_a ^ neg_b;
              neg_r_q  <= neg_a;
              dvs_q    <= mag_b;
              // Word operands start in the upper half so 32 steps consume them.
              quo_q    <= div.div_i_W_instr ? {mag_a[31:0], 32'b0} : mag_a;
              rem_q    <= '0;
              cnt      <= '0;
              if (div_zero | overflow) begin
                vale_q  <= fix_w(div.div_i_W_instr, sp_res);
                valid_q <= 1'b1;
                state   <= DONE;
              end else begin
                state <= CALC;
              end
            end
          end
          CALC: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + 7'd1;
            if (last) begin
              vale_q  <= res_fin;
              valid_q <= 1'b1;
              state   <= DONE;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign div.div_o_busy  = rst_n & ((state == CALC) |
                           ((state == IDLE) & div.div_i_start & ~div.div_i_flush));
  assign div.div_o_valid = valid_q;
  assign div.div_o_valE  = vale_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// tb/tb_exe_div_unit.sv - directed self-checking bench for exe_div_unit

module tb_exe_div_unit;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  exe_div_unit_if #(.XLEN(64)) dif ();

  exe_div_unit #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    dif.div_i_start   = 1'b1;
    dif.div_i_op      = op;
    dif.div_i_W_instr = w;
    dif.div_i_valA    = a;
    dif.div_i_valB    = b;
  endtask

  // Cycle 0 is the current cycle (start visible); counts cycles until valid.
  task automatic wait_result(input string tag, input int exp_lat, input logic [63:0] exp_val);
    int cyc;
    int busy_n;
    bit got;
    #1;
    busy_n = dif.div_o_busy ? 1 : 0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (dif.div_o_valid) got = 1'b1;
      else if (dif.div_o_busy) busy_n++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " busy cycles"}, 64'(busy_n), 64'(exp_lat));
    check({tag, " valE"}, dif.div_o_valE, exp_val);
    // start stays high through the DONE edge; it must not begin a new operation
    @(posedge clk);
    #1 dif.div_i_start = 1'b0;
    @(negedge clk);
    check({tag, " idle after done"}, {62'd0, dif.div_o_busy, dif.div_o_valid}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input int exp_lat, input logic [63:0] exp_val);
    launch(op, w, a, b);
    wait_result(tag, exp_lat, exp_val);
  endtask

  initial begin
    rst_n             = 1'b0;
    dif.div_i_start   = 1'b1;
    dif.div_i_op      = 2'b00;
    dif.div_i_W_instr = 1'b0;
    dif.div_i_valA    = 64'd100;
    dif.div_i_valB    = 64'd7;
    dif.div_i_flush   = 1'b0;
    #12;
    check("reset valid", {63'd0, dif.div_o_valid}, 64'd0);
    check("reset valE", dif.div_o_valE, 64'd0);
    check("reset busy with start", {63'd0, dif.div_o_busy}, 64'd0);
    @(negedge clk);
    dif.div_i_start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_op("DIV 100/-7",  2'b00, 1'b0, 64'd100, 64'hFFFFFFFFFFFFFFF9, 65, 64'hFFFFFFFFFFFFFFF2);
    run_op("REM 100/-7",  2'b10, 1'b0, 64'd100, 64'hFFFFFFFFFFFFFFF9, 65, 64'd2);
    run_op("DIVU /0",     2'b01, 1'b0, 64'h1234, 64'd0, 1, 64'hFFFFFFFFFFFFFFFF);
    run_op("REMU /0",     2'b11, 1'b0, 64'h1234, 64'd0, 1, 64'h1234);
    run_op("DIV ovf",     2'b00, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1, 64'h8000000000000000);
    run_op("REM ovf",     2'b10, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1, 64'd0);
    run_op("DIVW -7/2",   2'b00, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 33, 64'hFFFFFFFFFFFFFFFD);
    run_op("REMW -7/2",   2'b10, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 33, 64'hFFFFFFFFFFFFFFFF);
    run_op("DIVUW 2^31/1", 2'b01, 1'b1, 64'h0000000080000000, 64'd1, 33, 64'hFFFFFFFF80000000);
    run_op("DIVU max/16", 2'b01, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h10, 65, 64'h0FFFFFFFFFFFFFFF);
    run_op("REM -7/2",    2'b10, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 65, 64'hFFFFFFFFFFFFFFFF);

    // flush beats a simultaneous start in IDLE
    @(negedge clk);
    dif.div_i_start = 1'b1;
    dif.div_i_flush = 1'b1;
    #1 check("flush+start busy", {63'd0, dif.div_o_busy}, 64'd0);
    @(negedge clk);
    dif.div_i_start = 1'b0;
    dif.div_i_flush = 1'b0;
    #1 check("flush+start no op", {62'd0, dif.div_o_busy, dif.div_o_valid}, 64'd0);

    // flush at CALC cycle 10
    launch(2'b01, 1'b0, 64'd100, 64'd7);
    repeat (10) @(negedge clk);
    dif.div_i_flush = 1'b1;
    dif.div_i_start = 1'b0;
    @(negedge clk);
    dif.div_i_flush = 1'b0;
    check("flush busy", {63'd0, dif.div_o_busy}, 64'd0);
    begin
      int vcount;
      vcount = 0;
      repeat (70) begin
        @(negedge clk);
        if (dif.div_o_valid) vcount++;
      end
      check("flush no valid", 64'(vcount), 64'd0);
    end
    run_op("DIVU 10/3", 2'b01, 1'b0, 64'd10, 64'd3, 65, 64'd3);

    // asynchronous reset at CALC cycle 20, start held high through release
    launch(2'b01, 1'b0, 64'd100, 64'd7);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async rst valid", {63'd0, dif.div_o_valid}, 64'd0);
    check("async rst valE", dif.div_o_valE, 64'd0);
    check("async rst busy", {63'd0, dif.div_o_busy}, 64'd0);
    @(negedge clk);
    dif.div_i_op   = 2'b10;
    dif.div_i_valA = 64'd100;
    dif.div_i_valB = 64'hFFFFFFFFFFFFFFF9;
    @(negedge clk);
    check("rst held busy", {63'd0, dif.div_o_busy}, 64'd0);
    rst_n = 1'b1;
    wait_result("REM after rst", 65, 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_div_unit.md
EXE_DIV_UNIT -- requirements
Module: exe_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, the datapath width; only 64 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port div_i_start  input  1  the execute stage holds a divide/remainder instruction.
REQ-005 SHALL have port div_i_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port div_i_W_instr  input  1  32-bit word variant (DIVW/DIVUW/REMW/REMUW).
REQ-007 SHALL have port div_i_valA  input  64  dividend (rs1).
REQ-008 SHALL have port div_i_valB  input  64  divisor (rs2).
REQ-009 SHALL have port div_i_flush  input  1  kill the in-flight operation (branch redirect/exception).
REQ-010 SHALL have port div_o_busy  output  1  stall request to the pipeline; holds E stage and earlier.
REQ-011 SHALL have port div_o_valid  output  1  one-cycle pulse: div_o_valE holds the final result.
REQ-012 SHALL have port div_o_valE  output  64  quotient or remainder, per div_i_op.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-014 IDLE with div_i_start=1 and div_i_flush=0 SHALL latch the operands, op and W flag, and go to CALC (normal case) or to DONE (special case).
REQ-015 div_o_busy SHALL equal (state==CALC) | (state==IDLE & div_i_start & ~div_i_flush); it is combinational and low in DONE.
REQ-016 W variant SHALL use operand bits [31:0], sign-extended for DIV/REM and zero-extended for DIVU/REMU; the final result SHALL be sign-extended from bit 31.
REQ-017 Signed ops SHALL divide the operand magnitudes; quotient is negated when the operand signs differ, remainder takes the sign of the dividend.
REQ-018 CALC SHALL perform restoring division, one quotient bit per cycle, for N cycles (N=64 normal, N=32 W), tracked by a counter; then go to DONE.
REQ-019 Divide by zero (effective divisor 0) SHALL skip CALC: quotient = all ones, remainder = effective dividend.
REQ-020 Signed overflow (dividend = most negative value, divisor = -1, at the effective width) SHALL skip CALC: quotient = dividend, remainder = 0.
REQ-021 DONE SHALL assert div_o_valid for exactly one cycle with the result stable, then return to IDLE.
REQ-022 Latency: start accepted at cycle 0; valid at cycle N+1 (65 normal, 33 W); special cases valid at cycle 1.
REQ-023 div_i_start SHALL be sampled only in IDLE; the start level in DONE SHALL NOT start a new operation.
REQ-024 div_i_flush in any state SHALL force IDLE on the next edge with no valid pulse; flush wins over a simultaneous start.
REQ-025 div_o_valE SHALL hold its last value outside DONE; consumers use it only when div_o_valid=1.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, counter 0, div_o_valid 0, div_o_valE 0 and all internal registers 0, independent of clk.
REQ-027 Reset during CALC or DONE SHALL abandon the operation; no valid pulse follows release.
REQ-028 With rst_n=0, div_o_busy SHALL be 0 whatever div_i_start is.

Verification
REQ-029 DIV 100 / -7 -> busy for 65 cycles, valid at cycle 65, valE=0xFFFFFFFFFFFFFFF2 (-14); REM, same operands -> valE=2.
REQ-030 DIVU 0x1234 / 0 -> valid at cycle 1, valE=0xFFFFFFFFFFFFFFFF; REMU 0x1234 / 0 -> valE=0x1234.
REQ-031 DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> valid at cycle 1, valE=0x8000000000000000; REM, same operands -> valE=0.
REQ-032 DIVW valA=0x00000000FFFFFFF9 / valB=2 -> valid at cycle 33, valE=0xFFFFFFFFFFFFFFFD; REMW -> 0xFFFFFFFFFFFFFFFF; DIVUW 0x80000000 / 1 -> 0xFFFFFFFF80000000.
REQ-033 Flush at CALC cycle 10 -> IDLE and busy=0 next cycle, no valid; next start DIVU 10/3 -> valE=3 at cycle 65.
REQ-034 rst_n low at CALC cycle 20 -> valid, valE and busy read 0 before the next clk edge; start is held high through release; after release, a fresh operation starts and completes with the correct timing and result.
